// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the EX-stage branch redirect controller:
// branch funct3 encodings, redirect FSM states and the default datapath width.
package branch_ctrl_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } redir_state_e;

endpackage

// File: rtl/branch_compare.sv
// Branch condition evaluator for B-type instructions.
// Reserved funct3 encodings (010, 011) resolve as not taken.
module branch_compare
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            branch_taken
);

  // Select the comparison named by funct3
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      F3_BEQ:  branch_taken = (rs1 == rs2);
      F3_BNE:  branch_taken = (rs1 != rs2);
      F3_BLT:  branch_taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  branch_taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: branch_taken = (rs1 <  rs2);
      F3_BGEU: branch_taken = (rs1 >= rs2);
      default: branch_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_target_gen.sv
// Control-transfer target generation: pc+imm for branches and JAL,
// (rs1+imm) with bit 0 cleared for JALR. Both sums wrap modulo 2^XLEN.
module branch_target_gen
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic            is_jalr,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] pc_sum;
  logic [XLEN-1:0] rs_sum;

  assign pc_sum = pc + imm;
  assign rs_sum = rs1 + imm;

  // JALR wins over the pc-relative form so that illegal multi-hot
  // decode still follows jalr > jal > branch priority
  always_comb begin
    target = pc_sum;
    if (is_jalr) target = rs_sum & {{(XLEN-1){1'b1}}, 1'b0};
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch/jump resolution and PC redirect sequencer (predict-not-taken).
// Optional feature macro: BRANCH_PERF_EN adds saturating performance counters
// perf_branches, perf_taken and perf_misalign.
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int PERF_CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            stall_in,
  input  logic            fetch_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            hold_ex,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr
`ifdef BRANCH_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_branches,
  output logic [PERF_CNT_W-1:0] perf_taken,
  output logic [PERF_CNT_W-1:0] perf_misalign
`endif
);

  redir_state_e    state_q, state_d;
  logic [XLEN-1:0] target, target_q;
  logic            cmp_taken, accept, taken, misaligned;
  logic            do_redirect, do_misalign;

  branch_compare #(.XLEN(XLEN)) u_compare (
    .funct3       (ex_funct3),
    .rs1          (ex_rs1_data),
    .rs2          (ex_rs2_data),
    .branch_taken (cmp_taken)
  );

  branch_target_gen #(.XLEN(XLEN)) u_target (
    .pc      (ex_pc),
    .rs1     (ex_rs1_data),
    .imm     (ex_imm),
    .is_jalr (ex_is_jalr),
    .target  (target)
  );

  // An instruction is only resolved once, in IDLE, while EX is actually advancing
  assign accept      = (state_q == IDLE) & ex_valid & ~stall_in;
  assign taken       = ex_is_jalr | ex_is_jal | (ex_is_branch & cmp_taken);
  assign misaligned  = |target[1:0];
  assign do_redirect = accept & taken & ~misaligned;
  assign do_misalign = accept & taken & misaligned;

  // Redirect FSM state register; reset drops any pending redirect immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and Moore outputs; redirect_pc reads as zero outside REDIRECT
  always_comb begin
    state_d        = state_q;
    redirect_valid = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    hold_ex        = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      IDLE: begin
        if (do_redirect) state_d = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        flush_if_id    = 1'b1;
        flush_id_ex    = 1'b1;
        hold_ex        = 1'b1;
        redirect_pc    = target_q;
        if (fetch_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the redirect target on entry so it stays stable for the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           target_q <= '0;
    else if (do_redirect) target_q <= target;
  end

  // Single-cycle misalignment report, address cleared when no exception
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_exc  <= do_misalign;
      misalign_addr <= do_misalign ? target : '0;
    end
  end

`ifdef BRANCH_PERF_EN
  logic is_cf;
  assign is_cf = ex_is_branch | ex_is_jal | ex_is_jalr;

  // Saturating event counters for accepted control-flow instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches <= '0;
      perf_taken    <= '0;
      perf_misalign <= '0;
    end else begin
      if (accept && is_cf && perf_branches != '1) perf_branches <= perf_branches + 1'b1;
      if (accept && taken && perf_taken != '1)    perf_taken    <= perf_taken + 1'b1;
      if (do_misalign && perf_misalign != '1)     perf_misalign <= perf_misalign + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed vector table,
// hand-written reset sequence, then random stimulus against a reference model.
module tb_branch_redirect_ctrl;

  localparam int XLEN       = 32;
  localparam int PERF_CNT_W = 32;

  typedef struct {
    bit          valid;
    bit          is_branch;
    bit          is_jal;
    bit          is_jalr;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    bit          stall;
    bit          fready;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit          erv;
    logic [31:0] epc;
    bit          eexc;
    logic [31:0] eaddr;
  } row_t;

  logic            clk;
  logic            rst_n;
  logic            ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_pc, ex_imm;
  logic            stall_in, fetch_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_if_id, flush_id_ex, hold_ex, misalign_exc;
  logic [XLEN-1:0] misalign_addr;
`ifdef BRANCH_PERF_EN
  logic [PERF_CNT_W-1:0] perf_branches, perf_taken, perf_misalign;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: pending redirect flag/target and exception pulse
  bit          m_pend;
  logic [31:0] m_pc;
  bit          m_exc;
  logic [31:0] m_addr;

  branch_redirect_ctrl #(.XLEN(XLEN), .PERF_CNT_W(PERF_CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .ex_funct3      (ex_funct3),
    .ex_rs1_data    (ex_rs1_data),
    .ex_rs2_data    (ex_rs2_data),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .stall_in       (stall_in),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .hold_ex        (hold_ex),
    .misalign_exc   (misalign_exc),
    .misalign_addr  (misalign_addr)
`ifdef BRANCH_PERF_EN
    ,
    .perf_branches  (perf_branches),
    .perf_taken     (perf_taken),
    .perf_misalign  (perf_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mkStim(bit valid, bit br, bit jal, bit jalr, logic [2:0] f3,
                                   logic [31:0] rs1, logic [31:0] rs2, logic [31:0] pc,
                                   logic [31:0] imm, bit stall, bit fready);
    stim_t s;
    s.valid = valid; s.is_branch = br; s.is_jal = jal; s.is_jalr = jalr;
    s.funct3 = f3; s.rs1 = rs1; s.rs2 = rs2; s.pc = pc; s.imm = imm;
    s.stall = stall; s.fready = fready;
    return s;
  endfunction

  function automatic row_t mkRow(stim_t s, bit erv, logic [31:0] epc, bit eexc, logic [31:0] eaddr);
    row_t r;
    r.s = s; r.erv = erv; r.epc = epc; r.eexc = eexc; r.eaddr = eaddr;
    return r;
  endfunction

  // Branch outcome straight from the ISA definition of each condition
  function automatic bit refTaken(stim_t s);
    int a, b;
    a = int'(s.rs1);
    b = int'(s.rs2);
    if (s.is_jalr || s.is_jal) return 1'b1;
    if (!s.is_branch) return 1'b0;
    case (s.funct3)
      3'd0: return s.rs1 == s.rs2;
      3'd1: return s.rs1 != s.rs2;
      3'd4: return a < b;
      3'd5: return a >= b;
      3'd6: return s.rs1 < s.rs2;
      3'd7: return s.rs1 >= s.rs2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] refTarget(stim_t s);
    logic [31:0] t;
    if (s.is_jalr) begin
      t = s.rs1 + s.imm;
      t = t - (t % 2);
    end else begin
      t = s.pc + s.imm;
    end
    return t;
  endfunction

  // Drive one cycle of inputs, advance the clock and the reference model
  task automatic applyStimulus(input stim_t s);
    bit          n_pend, n_exc;
    logic [31:0] n_pc, n_addr, tgt;
    ex_valid     = s.valid;
    ex_is_branch = s.is_branch;
    ex_is_jal    = s.is_jal;
    ex_is_jalr   = s.is_jalr;
    ex_funct3    = s.funct3;
    ex_rs1_data  = s.rs1;
    ex_rs2_data  = s.rs2;
    ex_pc        = s.pc;
    ex_imm       = s.imm;
    stall_in     = s.stall;
    fetch_ready  = s.fready;
    n_pend = m_pend; n_pc = m_pc; n_exc = 1'b0; n_addr = 32'd0;
    if (m_pend) begin
      if (s.fready) n_pend = 1'b0;
    end else if (s.valid && !s.stall && refTaken(s)) begin
      tgt = refTarget(s);
      if (tgt % 4 != 0) begin
        n_exc  = 1'b1;
        n_addr = tgt;
      end else begin
        n_pend = 1'b1;
        n_pc   = tgt;
      end
    end
    @(posedge clk);
    #1;
    m_pend = n_pend; m_pc = n_pc; m_exc = n_exc; m_addr = n_addr;
  endtask

  task automatic cmp(input string name, input string sig, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s actual=%h required=%h", name, sig, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input bit erv, input logic [31:0] epc,
                             input bit eexc, input logic [31:0] eaddr);
    cmp(name, "redirect_valid", 32'(redirect_valid), 32'(erv));
    cmp(name, "redirect_pc",    redirect_pc,         epc);
    cmp(name, "flush_if_id",    32'(flush_if_id),    32'(erv));
    cmp(name, "flush_id_ex",    32'(flush_id_ex),    32'(erv));
    cmp(name, "hold_ex",        32'(hold_ex),        32'(erv));
    cmp(name, "misalign_exc",   32'(misalign_exc),   32'(eexc));
    cmp(name, "misalign_addr",  misalign_addr,       eaddr);
  endtask

  row_t  rows[$];
  stim_t idle;

  initial begin
    idle = mkStim(0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 1);
    m_pend = 0; m_pc = 0; m_exc = 0; m_addr = 0;
    rst_n = 1'b0;
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; ex_funct3 = 0;
    ex_rs1_data = 0; ex_rs2_data = 0; ex_pc = 0; ex_imm = 0; stall_in = 0; fetch_ready = 0;

    // Directed vectors: expected outputs are those seen after the row's clock edge
    rows.push_back(mkRow(mkStim(1,1,0,0,3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 0, 1), 1, 32'h120, 0, 0));
    rows.push_back(mkRow(idle, 0, 0, 0, 0));
    rows.push_back(mkRow(mkStim(1,1,0,0,3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 0, 1), 1, 32'h240, 0, 0));
    rows.push_back(mkRow(idle, 0, 0, 0, 0));
    rows.push_back(mkRow(mkStim(1,1,0,0,3'b110, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 0, 1), 0, 0, 0, 0));
    rows.push_back(mkRow(mkStim(1,0,0,1,3'b000, 32'h203, 32'd0, 32'h300, 32'd0, 0, 1), 0, 0, 1, 32'h202));
    rows.push_back(mkRow(mkStim(1,0,0,1,3'b000, 32'h201, 32'd0, 32'h300, 32'd0, 0, 1), 1, 32'h200, 0, 0));
    rows.push_back(mkRow(idle, 0, 0, 0, 0));
    rows.push_back(mkRow(mkStim(1,0,1,0,3'b000, 32'd0, 32'd0, 32'h400, 32'h80, 0, 0), 1, 32'h480, 0, 0));
    rows.push_back(mkRow(mkStim(1,1,0,0,3'b000, 32'd7, 32'd7, 32'h900, 32'h40, 0, 0), 1, 32'h480, 0, 0));
    rows.push_back(mkRow(mkStim(1,0,1,0,3'b000, 32'd0, 32'd0, 32'hA00, 32'h8, 1, 0), 1, 32'h480, 0, 0));
    rows.push_back(mkRow(mkStim(0,0,0,0,3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0), 1, 32'h480, 0, 0));
    rows.push_back(mkRow(mkStim(1,1,0,0,3'b000, 32'd3, 32'd3, 32'hB00, 32'h40, 0, 1), 0, 0, 0, 0));
    rows.push_back(mkRow(mkStim(1,1,0,0,3'b001, 32'd1, 32'd2, 32'h500, 32'h10, 1, 1), 0, 0, 0, 0));
    rows.push_back(mkRow(mkStim(1,1,0,0,3'b001, 32'd1, 32'd2, 32'h500, 32'h10, 1, 1), 0, 0, 0, 0));
    rows.push_back(mkRow(mkStim(1,1,0,0,3'b001, 32'd1, 32'd2, 32'h500, 32'h10, 0, 1), 1, 32'h510, 0, 0));
    rows.push_back(mkRow(idle, 0, 0, 0, 0));
    rows.push_back(mkRow(mkStim(1,0,1,0,3'b000, 32'd0, 32'd0, 32'hFFFFFFF0, 32'h20, 0, 1), 1, 32'h10, 0, 0));
    rows.push_back(mkRow(idle, 0, 0, 0, 0));
    rows.push_back(mkRow(mkStim(1,1,1,1,3'b000, 32'h1000, 32'd9, 32'h2000, 32'd4, 0, 1), 1, 32'h1004, 0, 0));
    rows.push_back(mkRow(idle, 0, 0, 0, 0));
    rows.push_back(mkRow(mkStim(1,1,0,0,3'b101, 32'hFFFFFFFF, 32'd0, 32'h600, 32'h40, 0, 1), 0, 0, 0, 0));
    rows.push_back(mkRow(mkStim(1,1,0,0,3'b111, 32'hFFFFFFFF, 32'd0, 32'h600, 32'hFFFFFFF8, 0, 1), 1, 32'h5F8, 0, 0));
    rows.push_back(mkRow(idle, 0, 0, 0, 0));
    rows.push_back(mkRow(mkStim(1,0,1,0,3'b000, 32'd0, 32'd0, 32'h700, 32'h6, 0, 1), 0, 0, 1, 32'h706));
    rows.push_back(mkRow(idle, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    foreach (rows[i]) begin
      applyStimulus(rows[i].s);
      checkOutput($sformatf("vec%0d", i), rows[i].erv, rows[i].epc, rows[i].eexc, rows[i].eaddr);
    end

    $display("[TB] reset during redirect");
    applyStimulus(mkStim(1,0,1,0,3'b000, 32'd0, 32'd0, 32'h800, 32'h100, 0, 0));
    checkOutput("rst_pre", 1, 32'h900, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    m_pend = 0; m_pc = 0; m_exc = 0; m_addr = 0;
    checkOutput("rst_async", 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(mkStim(1,1,0,0,3'b101, 32'd1, 32'd5, 32'h880, 32'h20, 0, 1));
    checkOutput("rst_bge_nt", 0, 0, 0, 0);
    applyStimulus(idle);
    checkOutput("rst_idle", 0, 0, 0, 0);

    $display("[TB] random stimulus");
    for (int n = 0; n < 400; n++) begin
      stim_t s;
      int    kind;
      kind        = int'($urandom_range(0, 9));
      s.valid     = ($urandom_range(0, 3) != 0);
      s.is_branch = (kind <= 4) || (kind == 9);
      s.is_jal    = (kind == 5) || (kind == 6) || (kind == 9);
      s.is_jalr   = (kind == 7) || (kind == 8);
      s.funct3    = 3'($urandom_range(0, 7));
      s.rs1       = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 7)) : $urandom;
      s.rs2       = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 7)) : $urandom;
      s.pc        = $urandom & 32'hFFFFFFFC;
      s.imm       = $urandom & 32'hFFFFFFFE;
      s.stall     = ($urandom_range(0, 3) == 0);
      s.fready    = ($urandom_range(0, 1) != 0);
      applyStimulus(s);
      checkOutput($sformatf("rnd%0d", n), m_pend, m_pend ? m_pc : 32'd0, m_exc, m_addr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
